color_sampler: RTL and testbench
================================

# color_sampler

Front-end sampler for the frequency-output colour sensor: drives the sensor's filter-select lines, counts output pulses over a fixed gate window for each of the clear, red, green and blue filters, and publishes the four counts together. It sits directly upstream of the percentage divider stage. Each colour count feeds that stage's colour operand, and the clear count feeds its divisor operand.

## Interface
- `WIDTH`, 15: count width; matches the divider operand width.
- `GATE_CYCLES`, 100000: clock cycles per measurement window.
- `SETTLE_CYCLES`, 1000: clock cycles to wait after each filter change before counting starts.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  when high, sweeps run back to back; when low, the block finishes the current sweep and then idles.
- `sensor_out`  in  1  asynchronous square wave from the sensor.
- `s2`, `s3`  out  1 each  filter select: clear=10, red=00, green=11, blue=01.
- `clear_cnt`, `red_cnt`, `green_cnt`, `blue_cnt`  out  WIDTH each  latched counts from the last completed sweep.
- `valid`  out  1  one-cycle pulse when the four counts update.
- `busy`  out  1  high while a sweep is in progress.

## Operation
- `sensor_out` passes through a 2-flop synchronizer, then a rising-edge detector. Each edge is counted 3 cycles after it appears on the pin.
- FSM states: IDLE, SETTLE, GATE, PUBLISH. A 2-bit channel index runs 0..3, in the order clear, red, green, blue.
- IDLE:
  - `busy` = 0; `s2/s3` hold clear (10).
  - `enable` = 1 -> SETTLE with channel 0 and the timer cleared.
- SETTLE:
  - `s2/s3` = code for the current channel.
  - Timer counts SETTLE_CYCLES cycles, then -> GATE with the timer and edge counter cleared.
  - Edges during SETTLE are ignored.
- GATE:
  - Each detected edge increments the edge counter, which saturates at 2^WIDTH-1 and never wraps.
  - After GATE_CYCLES cycles, the counter value goes into that channel's shadow register.
  - Channels 0..2 -> SETTLE for the next channel. Channel 3 -> PUBLISH.
  - An edge detected in the final gate cycle is counted.
- PUBLISH (1 cycle):
  - All four shadow registers copy to the outputs at once; `valid` = 1.
  - Then -> SETTLE with channel 0 if `enable` = 1, else -> IDLE.
- Outputs never change mid-sweep. Downstream logic sees four counts taken from one sweep.
- `enable` is sampled only in IDLE and PUBLISH. Dropping it mid-sweep does not abort the sweep.
- Internal timers are sized to fit max(GATE_CYCLES, SETTLE_CYCLES).

## Timing
- Reset values:
  - All count outputs 0; `valid` 0; `busy` 0.
  - `s2` 1, `s3` 0.
  - FSM IDLE; synchronizer flops 0.
- Reset mid-sweep:
  - Discards the shadow registers and returns to IDLE next cycle.
  - Published outputs are cleared to 0.
- Sweep latency, from the cycle `enable` is seen high in IDLE to the `valid` pulse: 4×(SETTLE_CYCLES+GATE_CYCLES)+1 cycles.
- Continuous-mode period: 4×(SETTLE_CYCLES+GATE_CYCLES)+1 cycles between `valid` pulses.
- `s2/s3` change on the cycle that SETTLE is entered for a new channel. They are registered outputs with no glitches.
- `busy` is high from the first SETTLE cycle through the PUBLISH cycle, inclusive.

## Configuration
- `COLOR_SAMPLER_ZERO_GUARD_EN` defined:
  - A clear count of 0 is published as 1, so the downstream divider never divides by zero.
  - Colour counts are unaffected.
- Not defined: `clear_cnt` is published exactly as counted, including 0.

## Test plan
- Bench parameters: WIDTH=15, GATE_CYCLES=100, SETTLE_CYCLES=10.
- Basic sweep:
  - Stimulus: `enable`=1; `sensor_out` period 10 clk, 50% duty, on all filters.
  - Required: `valid` 441 cycles after start; each count = 10; `s2/s3` sequence 10,00,11,01.
- Per-channel rates:
  - Stimulus: sensor period chosen per `s2/s3`: clear 4, red 10, green 20, blue 50 clk.
  - Required: clear 25, red 10, green 5, blue 2.
  - Required: with `enable` held high, the next `valid` follows exactly 441 cycles later.
- Saturation:
  - Stimulus: WIDTH=4, sensor period 2 clk.
  - Required: all counts = 15, no wrap.
- Reset mid-sweep:
  - Stimulus: assert `rst` during red GATE after a prior published sweep of 10s.
  - Required: next cycle all counts 0, `busy` 0, `s2/s3` = 10, no `valid`.
  - Required: after release with `enable`=1, a full sweep restarts from clear.
- Enable drop:
  - Stimulus: drop `enable` during green SETTLE.
  - Required: sweep completes, one `valid`, then IDLE with `busy` 0; no further `valid` over 1000 cycles.
- Zero guard:
  - Stimulus: `sensor_out` held 0 through the clear window.
  - Required: published `clear_cnt` = 1 with the macro defined, 0 without.

Source files
------------

// File: rtl/color_sampler.sv
// rtl/color_sampler.sv - colour sensor filter sweeper and pulse counter (optional COLOR_SAMPLER_ZERO_GUARD_EN)
module color_sampler #(
  parameter int WIDTH         = 15,
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sensor_out,
  output logic             s2,
  output logic             s3,
  output logic [WIDTH-1:0] clear_cnt,
  output logic [WIDTH-1:0] red_cnt,
  output logic [WIDTH-1:0] green_cnt,
  output logic [WIDTH-1:0] blue_cnt,
  output logic             valid,
  output logic             busy
);

  localparam int MAX_CYCLES = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX     = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    GATE    = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [TW-1:0]    timer_q;
  logic [2:0]       sync_q;
  logic             rise;
  logic [WIDTH-1:0] cnt_q, cnt_inc;
  logic [WIDTH-1:0] shadow_clear, shadow_red, shadow_green;
  logic [WIDTH-1:0] clear_pub;
  logic [1:0]       filter_q;
  logic             gate_done;

  // Filter-select code for each channel: clear, red, green, blue.
  function automatic logic [1:0] filter_code(input logic [1:0] ch);
    case (ch)
      2'd0:    return 2'b10;
      2'd1:    return 2'b00;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 3'b000;
    else     sync_q <= {sync_q[1:0], sensor_out};
  end

  assign rise      = sync_q[1] & ~sync_q[2];
  assign gate_done = (state_q == GATE) && (timer_q == GATE_LAST);
  assign cnt_inc   = (rise && (cnt_q != CNT_MAX)) ? cnt_q + WIDTH'(1) : cnt_q;

  // State and channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Next-state logic; enable only matters in IDLE and PUBLISH.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SETTLE;
          ch_d    = 2'd0;
        end
      end
      SETTLE: begin
        if (timer_q == SETTLE_LAST) state_d = GATE;
      end
      GATE: begin
        if (timer_q == GATE_LAST) begin
          if (ch_q == 2'd3) begin
            state_d = PUBLISH;
          end else begin
            state_d = SETTLE;
            ch_d    = ch_q + 2'd1;
          end
        end
      end
      PUBLISH: begin
        ch_d = 2'd0;
        if (enable) state_d = SETTLE;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase timer restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE) || (state_d != state_q)) timer_q <= '0;
    else                                                   timer_q <= timer_q + TW'(1);
  end

  // Saturating edge counter, live only for the duration of a gate window.
  always_ff @(posedge clk) begin
    if (rst)                                        cnt_q <= '0;
    else if ((state_q == GATE) && (state_d == GATE)) cnt_q <= cnt_inc;
    else                                            cnt_q <= '0;
  end

  // Shadow registers hold the first three channels until the sweep ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_clear <= '0;
      shadow_red   <= '0;
      shadow_green <= '0;
    end else if (gate_done) begin
      case (ch_q)
        2'd0:    shadow_clear <= cnt_inc;
        2'd1:    shadow_red   <= cnt_inc;
        2'd2:    shadow_green <= cnt_inc;
        default: ;
      endcase
    end
  end

`ifdef COLOR_SAMPLER_ZERO_GUARD_EN
  assign clear_pub = (shadow_clear == '0) ? WIDTH'(1) : shadow_clear;
`else
  assign clear_pub = shadow_clear;
`endif

  // All four counts publish together as the sweep enters PUBLISH; valid marks that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      clear_cnt <= '0;
      red_cnt   <= '0;
      green_cnt <= '0;
      blue_cnt  <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= gate_done && (ch_q == 2'd3);
      if (gate_done && (ch_q == 2'd3)) begin
        clear_cnt <= clear_pub;
        red_cnt   <= shadow_red;
        green_cnt <= shadow_green;
        blue_cnt  <= cnt_inc;
      end
    end
  end

  // Registered filter select: changes only when a channel's settle window opens.
  always_ff @(posedge clk) begin
    if (rst)                                          filter_q <= 2'b10;
    else if (state_d == IDLE)                         filter_q <= 2'b10;
    else if ((state_d == SETTLE) && (state_q != SETTLE)) filter_q <= filter_code(ch_d);
  end

  assign s2   = filter_q[1];
  assign s3   = filter_q[0];
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_color_sampler.sv
// tb/tb_color_sampler.sv - randomized self-checking bench for color_sampler
module tb_color_sampler;

  localparam int W   = 15;
  localparam int G   = 100;
  localparam int S   = 10;
  localparam int LAT = 4 * (S + G) + 1;
  localparam logic [3:0][1:0] CODES = {2'b01, 2'b11, 2'b00, 2'b10};

  logic clk = 1'b0;
  logic rst, enable, sensor_out;
  logic s2, s3, valid, busy;
  logic [W-1:0] clear_cnt, red_cnt, green_cnt, blue_cnt;

  logic rst_sat, en_sat, sensor_sat;
  logic s2_sat, s3_sat, valid_sat, busy_sat;
  logic [3:0] c_sat, r_sat, g_sat, b_sat;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic hist [0:32767];
  int per [4];
  int exp_c [4];
  int act_c [4];
  logic [3:0][1:0] seq;

  color_sampler #(.WIDTH(W), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensor_out(sensor_out),
    .s2(s2), .s3(s3),
    .clear_cnt(clear_cnt), .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt),
    .valid(valid), .busy(busy)
  );

  color_sampler #(.WIDTH(4), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut_sat (
    .clk(clk), .rst(rst_sat), .enable(en_sat), .sensor_out(sensor_sat),
    .s2(s2_sat), .s3(s3_sat),
    .clear_cnt(c_sat), .red_cnt(r_sat), .green_cnt(g_sat), .blue_cnt(b_sat),
    .valid(valid_sat), .busy(busy_sat)
  );

  always #5 clk = ~clk;

  function automatic int chan_of(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 1;
      2'b11:   return 2;
      2'b01:   return 3;
      default: return 0;
    endcase
  endfunction

  // Sensor waveform: period chosen by the filter currently selected; history kept per cycle.
  initial begin
    int ph, last_p, p;
    ph = 0;
    last_p = -1;
    sensor_sat = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      p = per[chan_of(s2, s3)];
      if (p != last_p) begin
        ph = 0;
        last_p = p;
      end
      if (p < 2) sensor_out = 1'b0;
      else begin
        sensor_out = (ph < p / 2);
        ph = (ph + 1) % p;
      end
      hist[cyc % 32768] = sensor_out;
      sensor_sat = ~sensor_sat;
    end
  end

  // Reference: rising edges whose count cycle (pin cycle + 2 detection, counted at end) lies in the gate.
  function automatic int model_cnt(input int c0, input int k, input int w);
    int n, lo, hi, mx;
    n  = 0;
    lo = c0 + 1 + S + (S + G) * k;
    hi = lo + G - 1;
    for (int m = lo; m <= hi; m++)
      if (hist[(m - 2) % 32768] === 1'b1 && hist[(m - 3) % 32768] === 1'b0) n++;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_pub(input int c0);
    for (int k = 0; k < 4; k++) exp_c[k] = model_cnt(c0, k, W);
`ifdef COLOR_SAMPLER_ZERO_GUARD_EN
    if (exp_c[0] == 0) exp_c[0] = 1;
`endif
  endtask

  task automatic load_act();
    act_c[0] = int'(clear_cnt);
    act_c[1] = int'(red_cnt);
    act_c[2] = int'(green_cnt);
    act_c[3] = int'(blue_cnt);
  endtask

  // Runs from the negedge of sweep-start cycle c0 until valid or the cycle budget expires.
  task automatic run_sweep(input int drop_at, output int vcyc, output int busy_low);
    vcyc = -1;
    busy_low = 0;
    for (int i = 1; i <= LAT + 50; i++) begin
      @(negedge clk);
      if (drop_at == i) enable = 1'b0;
      for (int k = 0; k < 4; k++)
        if (i == 1 + (S + G) * k) seq[k] = {s2, s3};
      if (busy !== 1'b1) busy_low++;
      if (valid === 1'b1) begin
        vcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_sat = 1'b1; enable = 1'b0; en_sat = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({clear_cnt, red_cnt, green_cnt, blue_cnt} !== '0) begin
      failures++; $display("FAIL reset_counts: got %h expected 0", {clear_cnt, red_cnt, green_cnt, blue_cnt});
    end
    checks++;
    if ({valid, busy} !== 2'b00) begin
      failures++; $display("FAIL reset_valid_busy: got %b expected 00", {valid, busy});
    end
    checks++;
    if ({s2, s3} !== 2'b10) begin
      failures++; $display("FAIL reset_s2s3: got %b expected 10", {s2, s3});
    end
    checks++;
    if ({c_sat, r_sat, g_sat, b_sat, valid_sat, busy_sat, s2_sat, s3_sat} !== 20'h00002) begin
      failures++; $display("FAIL reset_sat: got %h expected 00002", {c_sat, r_sat, g_sat, b_sat, valid_sat, busy_sat, s2_sat, s3_sat});
    end
    rst = 1'b0; rst_sat = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int c0, v, bl;
    per = '{10, 10, 10, 10};
    @(negedge clk);
    c0 = cyc; enable = 1'b1;
    run_sweep(0, v, bl);
    enable = 1'b0;
    checks++;
    if (v - c0 != LAT) begin
      failures++; $display("FAIL basic_latency: got %0d expected %0d", v - c0, LAT);
    end
    checks++;
    if (seq !== CODES) begin
      failures++; $display("FAIL basic_s2s3_seq: got %b expected %b", seq, CODES);
    end
    checks++;
    if (bl != 0) begin
      failures++; $display("FAIL basic_busy: got %0d low cycles expected 0", bl);
    end
    model_pub(c0);
    load_act();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_c[k] != 10 || act_c[k] != exp_c[k]) begin
        failures++; $display("FAIL basic_cnt%0d: got %0d expected 10 (model %0d)", k, act_c[k], exp_c[k]);
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, valid, s2, s3} !== 4'b0010) begin
      failures++; $display("FAIL basic_idle: got %b expected 0010", {busy, valid, s2, s3});
    end
  endtask

  task automatic test_rates();
    int c0, v, v2, bl;
    int fixed [4];
    fixed = '{25, 10, 5, 2};
    per = '{4, 10, 20, 50};
    @(negedge clk);
    c0 = cyc; enable = 1'b1;
    run_sweep(0, v, bl);
    model_pub(c0);
    load_act();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_c[k] != fixed[k] || act_c[k] != exp_c[k]) begin
        failures++; $display("FAIL rates_cnt%0d: got %0d expected %0d (model %0d)", k, act_c[k], fixed[k], exp_c[k]);
      end
    end
    run_sweep(0, v2, bl);
    enable = 1'b0;
    checks++;
    if (v2 - v != LAT) begin
      failures++; $display("FAIL rates_period: got %0d expected %0d", v2 - v, LAT);
    end
    model_pub(v);
    load_act();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_c[k] != exp_c[k]) begin
        failures++; $display("FAIL rates2_cnt%0d: got %0d expected %0d", k, act_c[k], exp_c[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int c0, v;
    v = -1;
    @(negedge clk);
    c0 = cyc; en_sat = 1'b1;
    for (int i = 1; i <= LAT + 50; i++) begin
      @(negedge clk);
      if (valid_sat === 1'b1) begin
        v = cyc;
        break;
      end
    end
    en_sat = 1'b0;
    checks++;
    if (v - c0 != LAT) begin
      failures++; $display("FAIL sat_latency: got %0d expected %0d", v - c0, LAT);
    end
    checks++;
    if ({c_sat, r_sat, g_sat, b_sat} !== 16'hffff) begin
      failures++; $display("FAIL sat_counts: got %h expected ffff", {c_sat, r_sat, g_sat, b_sat});
    end
    @(negedge clk);
    checks++;
    if (busy_sat !== 1'b0) begin
      failures++; $display("FAIL sat_idle: got %b expected 0", busy_sat);
    end
  endtask

  task automatic test_reset_mid();
    int c0, v, bl;
    per = '{10, 10, 10, 10};
    @(negedge clk);
    c0 = cyc; enable = 1'b1;
    run_sweep(0, v, bl);
    checks++;
    if ({clear_cnt, red_cnt, green_cnt, blue_cnt} !== {4{W'(10)}}) begin
      failures++; $display("FAIL rstmid_prior: got %0d %0d %0d %0d expected 10s", clear_cnt, red_cnt, green_cnt, blue_cnt);
    end
    repeat (2 * S + G + 40) @(negedge clk);
    checks++;
    if ({busy, s2, s3} !== 3'b100) begin
      failures++; $display("FAIL rstmid_in_red: got %b expected 100", {busy, s2, s3});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({clear_cnt, red_cnt, green_cnt, blue_cnt} !== '0 || {busy, valid, s2, s3} !== 4'b0010) begin
      failures++; $display("FAIL rstmid_cleared: got cnt %h flags %b expected 0 / 0010", {clear_cnt, red_cnt, green_cnt, blue_cnt}, {busy, valid, s2, s3});
    end
    rst = 1'b0;
    c0 = cyc;
    run_sweep(0, v, bl);
    enable = 1'b0;
    checks++;
    if (v - c0 != LAT || seq !== CODES) begin
      failures++; $display("FAIL rstmid_restart: got latency %0d seq %b expected %0d %b", v - c0, seq, LAT, CODES);
    end
    model_pub(c0);
    load_act();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_c[k] != 10 || act_c[k] != exp_c[k]) begin
        failures++; $display("FAIL rstmid_cnt%0d: got %0d expected 10 (model %0d)", k, act_c[k], exp_c[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_enable_drop();
    int c0, v, bl, extra_valid, extra_busy;
    for (int k = 0; k < 4; k++) per[k] = int'($urandom_range(2, 40));
    @(negedge clk);
    c0 = cyc; enable = 1'b1;
    run_sweep(2 * (S + G) + 1 + S / 2, v, bl);
    checks++;
    if (v - c0 != LAT || bl != 0) begin
      failures++; $display("FAIL drop_complete: got latency %0d busy_low %0d expected %0d 0", v - c0, bl, LAT);
    end
    model_pub(c0);
    load_act();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_c[k] != exp_c[k]) begin
        failures++; $display("FAIL drop_cnt%0d: got %0d expected %0d (period %0d)", k, act_c[k], exp_c[k], per[k]);
      end
    end
    extra_valid = 0;
    extra_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (valid === 1'b1) extra_valid++;
      if (busy !== 1'b0) extra_busy++;
    end
    checks++;
    if (extra_valid != 0 || extra_busy != 0) begin
      failures++; $display("FAIL drop_idle: got valid %0d busy %0d expected 0 0", extra_valid, extra_busy);
    end
  endtask

  task automatic test_zero_guard();
    int c0, v, bl, want;
    per = '{0, 10, 10, 10};
    repeat (5) @(negedge clk);
    c0 = cyc; enable = 1'b1;
    run_sweep(0, v, bl);
    enable = 1'b0;
`ifdef COLOR_SAMPLER_ZERO_GUARD_EN
    want = 1;
`else
    want = 0;
`endif
    model_pub(c0);
    checks++;
    if (int'(clear_cnt) != want || int'(clear_cnt) != exp_c[0]) begin
      failures++; $display("FAIL zero_clear: got %0d expected %0d (model %0d)", clear_cnt, want, exp_c[0]);
    end
    checks++;
    if ({red_cnt, green_cnt, blue_cnt} !== {3{W'(10)}}) begin
      failures++; $display("FAIL zero_colours: got %0d %0d %0d expected 10s", red_cnt, green_cnt, blue_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c0, v, bl;
    for (int k = 0; k < 4; k++) per[k] = int'($urandom_range(2, 30));
    @(negedge clk);
    c0 = cyc; enable = 1'b1;
    for (int s = 0; s < 3; s++) begin
      run_sweep(0, v, bl);
      checks++;
      if (v - c0 != LAT) begin
        failures++; $display("FAIL b2b_period%0d: got %0d expected %0d", s, v - c0, LAT);
      end
      model_pub(c0);
      load_act();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act_c[k] != exp_c[k]) begin
          failures++; $display("FAIL b2b_cnt%0d_%0d: got %0d expected %0d (period %0d)", s, k, act_c[k], exp_c[k], per[k]);
        end
      end
      c0 = v;
      for (int k = 0; k < 4; k++) per[k] = int'($urandom_range(2, 30));
      if (s == 2) enable = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rst_sat = 1'b1;
    enable = 1'b0; en_sat = 1'b0;
    sensor_out = 1'b0;
    per = '{10, 10, 10, 10};
    test_reset();
    test_basic();
    test_rates();
    test_saturation();
    test_reset_mid();
    test_enable_drop();
    test_zero_guard();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
